wb_dma_copy: RTL and testbench

- Word-granular memory-to-memory copy engine, acting as one bus master feeding a slave port of the shared Wishbone-style arbiter.
- Software programs source address, destination address and length through a small CSR slave port, then starts the copy.
- The engine issues alternating single-word read and write transactions, then flags completion through a status bit and an IRQ line.

---
 rtl/wb_dma_copy_pkg.sv | 13 +
 rtl/wb_dma_copy.sv | 119 +++++++++++
 tb/tb_wb_dma_copy.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_dma_copy_pkg.sv
// wb_dma_copy_pkg: register offsets, CSR bit positions and FSM states shared by the copy engine and its bench
package wb_dma_copy_pkg;
  localparam logic [1:0] REG_CSR = 2'd0;
  localparam logic [1:0] REG_SRC = 2'd1;
  localparam logic [1:0] REG_DST = 2'd2;
  localparam logic [1:0] REG_LEN = 2'd3;
  localparam int BIT_BUSY = 0;
  localparam int BIT_DONE = 1;
  localparam int BIT_ABORTED = 2;
  localparam int BIT_ABORT = 3;
  localparam int BIT_START = 4;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WGAP, S_WR, S_NEXT, S_FIN} state_t;
endpackage

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: word-granular memory-to-memory copy engine with a CSR slave and one Wishbone-style master
module wb_dma_copy
  import wb_dma_copy_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MW = DW / 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    c_addr,
  output logic [DW-1:0] c_rdata,
  input  logic [DW-1:0] c_wdata,
  input  logic          c_we,
  input  logic          c_cyc,
  output logic          c_ack,
  output logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_rdata,
  output logic [DW-1:0] m_wdata,
  output logic [MW-1:0] m_wmsk,
  output logic          m_we,
  output logic          m_cyc,
  input  logic          m_ack,
  output logic          irq
);
  state_t state;
  logic busy, done, aborted, abort_pend;
  logic [AW-1:0] src, dst;
  logic [LW-1:0] len;
  logic csr_wr, ctl_wr, cfg_wr, start, abort;
  logic unused_wdata;
  assign csr_wr = c_cyc && c_ack && c_we;
  assign ctl_wr = csr_wr && c_addr == REG_CSR;
  assign cfg_wr = csr_wr && !busy;
  assign start = ctl_wr && c_wdata[BIT_START] && !busy;
  assign abort = ctl_wr && c_wdata[BIT_ABORT] && busy;
  assign unused_wdata = ^c_wdata;
  assign m_wmsk = '0;
  assign irq = done;
  always_comb
    c_rdata = !c_ack ? '0 :
              c_addr == REG_CSR ? DW'({aborted, done, busy}) :
              c_addr == REG_SRC ? DW'(src) :
              c_addr == REG_DST ? DW'(dst) : DW'(len);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      abort_pend <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
      c_ack <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_we <= 1'b0;
      m_cyc <= 1'b0;
    end else begin
      c_ack <= c_cyc && !c_ack;
      if (cfg_wr && c_addr == REG_SRC) src <= c_wdata[AW-1:0];
      if (cfg_wr && c_addr == REG_DST) dst <= c_wdata[AW-1:0];
      if (cfg_wr && c_addr == REG_LEN) len <= c_wdata[LW-1:0];
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          done <= 1'b0;
          aborted <= 1'b0;
          abort_pend <= 1'b0;
          state <= len == '0 ? S_FIN : S_RD;
          m_cyc <= len != '0;
          m_we <= 1'b0;
          m_addr <= src;
        end
        S_RD: if (m_ack) begin
          m_wdata <= m_rdata;
          m_cyc <= 1'b0;
          state <= S_WGAP;
        end
        S_WGAP: if (abort_pend) state <= S_FIN;
        else begin
          state <= S_WR;
          m_cyc <= 1'b1;
          m_we <= 1'b1;
          m_addr <= dst;
        end
        S_WR: if (m_ack) begin
          m_cyc <= 1'b0;
          m_we <= 1'b0;
          state <= S_NEXT;
        end
        S_NEXT: begin
          src <= src + 1'b1;
          dst <= dst + 1'b1;
          len <= len - 1'b1;
          if (len != LW'(1) && !abort_pend) begin
            state <= S_RD;
            m_cyc <= 1'b1;
            m_addr <= src + 1'b1;
          end else state <= S_FIN;
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          aborted <= abort_pend;
          abort_pend <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // software W1C/pulse writes win over same-cycle FSM updates
      if (abort) abort_pend <= 1'b1;
      if (ctl_wr && c_wdata[BIT_DONE]) done <= 1'b0;
      if (ctl_wr && c_wdata[BIT_ABORTED]) aborted <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: self-checking bench with a memory slave, protocol monitor and queue-based copy model
module tb_wb_dma_copy;
  import wb_dma_copy_pkg::*;
  logic clk = 0, rst = 1;
  logic [1:0] c_addr = 0;
  logic [31:0] c_rdata, c_wdata = 0, m_rdata = 0, m_wdata;
  logic c_we = 0, c_cyc = 0, c_ack, m_we, m_cyc, m_ack = 0, irq;
  logic [15:0] m_addr;
  logic [3:0] m_wmsk;
  always #5 clk = ~clk;
  wb_dma_copy dut (
    .clk(clk), .rst(rst), .c_addr(c_addr), .c_rdata(c_rdata), .c_wdata(c_wdata), .c_we(c_we),
    .c_cyc(c_cyc), .c_ack(c_ack), .m_addr(m_addr), .m_rdata(m_rdata), .m_wdata(m_wdata),
    .m_wmsk(m_wmsk), .m_we(m_we), .m_cyc(m_cyc), .m_ack(m_ack), .irq(irq)
  );
  typedef struct { logic [15:0] a; logic [31:0] d; } txn_t;
  typedef struct { logic [1:0] a; logic we; logic [31:0] wd; logic [31:0] exp; } vec_t;
  logic [31:0] mem [0:65535];
  txn_t rd_q[$], wr_q[$];
  int unsigned dmin = 0, dmax = 5, cnt = 0;
  int nchk = 0, nfail = 0, proto_err = 0;
  logic prev_cyc = 0, prev_ack = 0, cyc_seen = 0;
  logic [48:0] hold = 0;
  // memory slave with random wait states plus a bus-protocol monitor
  always @(negedge clk) begin
    if (rst) begin
      m_ack = 0; cnt = 0; prev_cyc = 0; prev_ack = 0;
    end else begin
      if (prev_cyc && !m_cyc && !prev_ack) proto_err++;
      if (prev_ack && m_cyc) proto_err++;
      if (prev_cyc && m_cyc && !prev_ack && hold != {m_addr, m_we, m_wdata}) proto_err++;
      if (m_cyc && m_we && m_wmsk != 0) proto_err++;
      if (m_cyc) cyc_seen = 1;
      if (m_ack) m_ack = 0;
      else if (m_cyc) begin
        if (cnt == 0) begin
          m_ack = 1;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            wr_q.push_back('{m_addr, m_wdata});
          end else begin
            m_rdata = mem[m_addr];
            rd_q.push_back('{m_addr, mem[m_addr]});
          end
          cnt = $urandom_range(dmax, dmin);
        end else cnt--;
      end
      prev_ack = m_ack; prev_cyc = m_cyc; hold = {m_addr, m_we, m_wdata};
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic csr(input logic [1:0] a, input logic we, input logic [31:0] wd, output logic [31:0] rd);
    int n = 0;
    c_addr = a; c_we = we; c_wdata = wd; c_cyc = 1;
    do begin @(negedge clk); n++; end while (!c_ack && n < 8);
    check("csr_ack", {31'b0, c_ack}, 1);
    rd = c_rdata;
    @(posedge clk); #1;
    c_cyc = 0; c_we = 0;
  endtask
  task automatic csr_w(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    csr(a, 1, d, v);
  endtask
  task automatic csr_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr(a, 0, 0, v);
    check(nm, v, exp);
  endtask
  task automatic wait_irq(input int lim);
    int n = 0;
    while (!irq && n < lim) begin @(negedge clk); n++; end
    check("irq_wait", {31'b0, irq}, 1);
  endtask
  // reference: word i is read from s+i and written to d+i (mod 2^16) with the pre-copy source data
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int l, input bit poke);
    logic [31:0] sd[$];
    for (int i = 0; i < l; i++) sd.push_back(mem[16'(s + i)]);
    rd_q.delete(); wr_q.delete();
    csr_w(REG_SRC, 32'(s)); csr_w(REG_DST, 32'(d)); csr_w(REG_LEN, l);
    csr_w(REG_CSR, 32'(1) << BIT_START);
    if (poke) csr_w(REG_SRC, 32'h5555);
    wait_irq(40 * l + 40);
    check("rd_count", rd_q.size(), l);
    check("wr_count", wr_q.size(), l);
    for (int i = 0; i < l && i < rd_q.size() && i < wr_q.size(); i++) begin
      check("rd_addr", rd_q[i].a, 16'(s + i));
      check("wr_addr", wr_q[i].a, 16'(d + i));
      check("wr_data", wr_q[i].d, sd[i]);
    end
    csr_chk("csr_done", REG_CSR, 32'h2);
    csr_chk("src_end", REG_SRC, 32'(16'(s + l)));
    csr_chk("dst_end", REG_DST, 32'(16'(d + l)));
    csr_chk("len_end", REG_LEN, 0);
    check("protocol", proto_err, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d failures", nchk, nfail);
    $fatal(1);
  end
  initial begin
    vec_t tv[12];
    logic [31:0] v;
    int n;
    tv[0] = '{REG_CSR, 0, 0, 0};
    tv[1] = '{REG_SRC, 0, 0, 0};
    tv[2] = '{REG_DST, 0, 0, 0};
    tv[3] = '{REG_LEN, 0, 0, 0};
    tv[4] = '{REG_SRC, 1, 32'h0001_1234, 0};
    tv[5] = '{REG_SRC, 0, 0, 32'h1234};
    tv[6] = '{REG_DST, 1, 32'hABCD, 0};
    tv[7] = '{REG_DST, 0, 0, 32'hABCD};
    tv[8] = '{REG_LEN, 1, 32'h0005, 0};
    tv[9] = '{REG_LEN, 0, 0, 32'h5};
    tv[10] = '{REG_CSR, 1, 32'h0E, 0};
    tv[11] = '{REG_CSR, 0, 0, 0};
    repeat (3) @(negedge clk);
    check("rst_m_cyc", {31'b0, m_cyc}, 0);
    check("rst_c_ack", {31'b0, c_ack}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_m_out", {m_addr, m_wdata, m_we, m_wmsk}, 0);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      csr(tv[i].a, tv[i].we, tv[i].wd, v);
      if (!tv[i].we) check($sformatf("vec%0d", i), v, tv[i].exp);
    end
    mem[16'h0010] = 32'hDEADBEEF;
    run_copy(16'h0010, 16'h0100, 1, 0);
    check("single_mem", mem[16'h0100], 32'hDEADBEEF);
    check("single_irq", {31'b0, irq}, 1);
    csr_w(REG_LEN, 0);
    cyc_seen = 0;
    csr_w(REG_CSR, 32'(1) << BIT_START);
    n = 0;
    while (!irq && n < 3) begin @(negedge clk); n++; end
    check("zero_done", {31'b0, irq}, 1);
    check("zero_no_cyc", {31'b0, cyc_seen}, 0);
    for (int i = 0; i < 4; i++) mem[16'h0200 + i] = $urandom;
    run_copy(16'h0200, 16'h0300, 4, 1);
    for (int k = 0; k < 6; k++) begin
      logic [15:0] s, d;
      s = 16'($urandom_range(16'h3FFF, 16'h0400));
      d = 16'($urandom_range(16'hBFFF, 16'h8000));
      for (int i = 0; i < 8; i++) mem[16'(s + i)] = $urandom;
      run_copy(s, d, k == 0 ? 8 : $urandom_range(8, 1), 0);
    end
    mem[16'hFFFF] = $urandom; mem[16'h0000] = $urandom;
    run_copy(16'hFFFF, 16'h7FFF, 2, 0);
    dmin = 5; dmax = 5;
    rd_q.delete(); wr_q.delete();
    csr_w(REG_SRC, 32'h1000); csr_w(REG_DST, 32'h9000); csr_w(REG_LEN, 100);
    csr_w(REG_CSR, 32'(1) << BIT_START);
    n = 0;
    while (!(rd_q.size() == 2 && wr_q.size() == 2 && m_cyc && !m_we) && n < 500) begin @(negedge clk); n++; end
    check("abort_reach_rd3", {31'b0, n < 500}, 1);
    csr_w(REG_CSR, 32'(1) << BIT_ABORT);
    wait_irq(100);
    repeat (20) @(negedge clk);
    check("abort_rd_count", rd_q.size(), 3);
    check("abort_wr_count", wr_q.size(), 2);
    csr_chk("abort_csr", REG_CSR, 32'h6);
    csr_chk("abort_len", REG_LEN, 98);
    csr_chk("abort_src", REG_SRC, 32'h1002);
    check("abort_protocol", proto_err, 0);
    dmin = 4; dmax = 4;
    csr_w(REG_SRC, 32'h2000); csr_w(REG_DST, 32'hA000); csr_w(REG_LEN, 4);
    csr_w(REG_CSR, 32'(1) << BIT_START);
    n = 0;
    while (!(m_cyc && m_we) && n < 100) begin @(negedge clk); n++; end
    check("rst_reach_wr", {31'b0, m_cyc && m_we}, 1);
    #2 rst = 1;
    #1 check("rst_mid_cyc", {31'b0, m_cyc}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    csr_chk("rst_csr", REG_CSR, 0);
    csr_chk("rst_src", REG_SRC, 0);
    csr_chk("rst_dst", REG_DST, 0);
    csr_chk("rst_len", REG_LEN, 0);
    dmin = 0; dmax = 5;
    for (int i = 0; i < 4; i++) mem[16'h2000 + i] = $urandom;
    run_copy(16'h2000, 16'hA000, 4, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
